// File: rtl/store_write_buffer_pkg.sv
// ============================================================================
// Module      : store_write_buffer_pkg
// Description : Shared types for the store write buffer: access size codes,
//               buffer FSM states and the formatted byte-lane payload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_write_buffer_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } sb_state_t;

  // Bus-ready payload of one queued store (address kept separately so its
  // width can follow the ADDR_W parameter of the instantiating module).
  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } sb_lane_t;

endpackage

`default_nettype wire

// File: rtl/store_write_buffer_if.sv
// ============================================================================
// Module      : store_write_buffer_if
// Description : SRAM-like write bus between the store buffer (master) and
//               the data memory (slave): req/addr_ok/data_ok handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface store_write_buffer_if #(
  parameter int ADDR_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok
  );
endinterface

`default_nettype wire

// File: rtl/store_write_buffer_fmt.sv
// ============================================================================
// Module      : store_write_buffer_fmt
// Description : Combinational store formatter. Replicates sb/sh/sw data over
//               the byte lanes and builds byte strobes.
//               Macro UNALIGNED_EXC_EN: report misaligned stores instead of
//               silently aligning the address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_write_buffer_fmt
  import store_write_buffer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic [31:0]       data,
  output logic [ADDR_W-1:0] addr_al,
  output sb_lane_t          lane,
  output logic              misaligned
);

  logic is_half;
  logic is_word;

  // Reserved size 2'b11 behaves exactly like a word access.
  assign is_half = (size == SIZE_HALF);
  assign is_word = (size == SIZE_WORD) || (size == 2'b11);

  // Alignment handling, then lane replication and strobe generation.
  always_comb begin
    addr_al    = addr;
    misaligned = 1'b0;
    lane       = '0;
`ifdef UNALIGNED_EXC_EN
    misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
    if (is_half) addr_al[0]   = 1'b0;
    if (is_word) addr_al[1:0] = 2'b00;
`endif
    lane.size = size;
    case (size)
      SIZE_BYTE: begin
        lane.wdata = {4{data[7:0]}};
        lane.wstrb = 4'b0001 << addr_al[1:0];
      end
      SIZE_HALF: begin
        lane.wdata = {2{data[15:0]}};
        lane.wstrb = addr_al[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane.wdata = data;
        lane.wstrb = 4'b1111;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/store_write_buffer.sv
// ============================================================================
// Module      : store_write_buffer
// Description : In-order store queue from the MEM stage to the data bus.
//               Holds up to DEPTH formatted stores and issues them one at a
//               time over req/addr_ok/data_ok with a single write outstanding.
//               Macro UNALIGNED_EXC_EN: misaligned stores raise st_ades and
//               are dropped instead of being force-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_W-1:0]     st_addr,
  input  logic [31:0]           st_data,
  input  logic [1:0]            st_size,
  output logic                  sb_empty,
  output logic                  st_ades,
  store_write_buffer_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  sb_lane_t          lane_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  sb_state_t         state;
  sb_state_t         state_next;

  logic [ADDR_W-1:0] fmt_addr;
  sb_lane_t          fmt_lane;
  logic              fmt_mis;
  logic              push;
  logic              pop;

  store_write_buffer_fmt #(
    .ADDR_W (ADDR_W)
  ) u_fmt (
    .addr       (st_addr),
    .size       (st_size),
    .data       (st_data),
    .addr_al    (fmt_addr),
    .lane       (fmt_lane),
    .misaligned (fmt_mis)
  );

  // A full queue frees a slot only on the cycle after a pop, so st_ready
  // depends on the registered count alone.
  assign st_ready = (count != CNT_W'(DEPTH));
  assign st_ades  = st_valid && st_ready && fmt_mis;
  assign push     = st_valid && st_ready && !fmt_mis;
  assign pop      = (state == WAIT) && bus.data_data_ok;
  assign sb_empty = (count == '0) && (state == IDLE);

  // Head entry drives the bus; it cannot change while REQ is pending.
  assign bus.data_req   = (state == REQ);
  assign bus.data_wr    = 1'b1;
  assign bus.data_addr  = addr_mem[rd_ptr];
  assign bus.data_size  = lane_mem[rd_ptr].size;
  assign bus.data_wdata = lane_mem[rd_ptr].wdata;
  assign bus.data_wstrb = lane_mem[rd_ptr].wstrb;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Queue storage, pointers and occupancy counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        lane_mem[i] <= '0;
      end
    end else begin
      count <= count_next;
      if (push) begin
        addr_mem[wr_ptr] <= fmt_addr;
        lane_mem[wr_ptr] <= fmt_lane;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Issue FSM next state; an incoming push leaves IDLE at once so the bus
  // request appears one cycle after the store is accepted.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if ((count != '0) || push) state_next = REQ;
      end
      REQ: begin
        if (bus.data_addr_ok) state_next = WAIT;
      end
      WAIT: begin
        if (bus.data_data_ok) state_next = (count_next != '0) ? REQ : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire
